vga_sync_receiver: RTL and testbench

//  Receive end of the VGA link: takes hsync/vsync/RGB as produced by the VGA controller path and recovers pixel timing.

---
 rtl/vga_sync_receiver_pkg.sv | 21 ++
 rtl/vga_sync_receiver_sync_edge_detect.sv | 22 ++
 rtl/vga_sync_receiver.sv | 125 ++++++++++++
 tb/tb_vga_sync_receiver.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/vga_sync_receiver_pkg.sv
// vga_sync_receiver_pkg: default 640x480 timing, sync polarity, FSM state encodings and CRC helper
// Shared with the controller side so both ends agree on the mode.
package vga_sync_receiver_pkg;
  localparam int unsigned DEF_H_SYNC  = 96;
  localparam int unsigned DEF_H_BP    = 48;
  localparam int unsigned DEF_H_ACT   = 640;
  localparam int unsigned DEF_H_TOTAL = 800;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BP    = 33;
  localparam int unsigned DEF_V_ACT   = 480;
  localparam int unsigned DEF_V_TOTAL = 525;
  localparam bit DEF_SYNC_POL = 1'b0;
  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_e;
  // CRC-16-CCITT (poly 0x1021, MSB first) advanced by one byte
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? {r[14:0], 1'b0} ^ 16'h1021 : {r[14:0], 1'b0};
    return r;
  endfunction
endpackage

// File: rtl/vga_sync_receiver_sync_edge_detect.sv
// vga_sync_receiver_sync_edge_detect: registers one sync input and strobes when it enters its pulse level
// Ports: clk; rst (sync, active-low); sync_i raw sync; strobe_o one cycle at pulse start.
module vga_sync_receiver_sync_edge_detect #(
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_i,
  output logic strobe_o
);
  logic sync_q, prev_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= ~SYNC_POL;
      prev_q <= ~SYNC_POL;
    end else begin
      sync_q <= sync_i;
      prev_q <= sync_q;
    end
  end
  assign strobe_o = (sync_q == SYNC_POL) && (prev_q != SYNC_POL);
endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers VGA pixel timing from hsync/vsync/RGB, locks to the mode, emits x/y-tagged pixels
// Ports: clk; rst (sync, active-low); hsync_in, vsync_in, r_in, g_in, b_in from the link;
//   pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b pixel stream (2 cycles after input); frame_start at (0,0);
//   locked; err_count (saturating timing-violation count);
//   frame_crc CRC-16-CCITT of the previous locked frame, present only when FRAME_CRC_EN is defined.
module vga_sync_receiver import vga_sync_receiver_pkg::*; #(
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BP    = DEF_H_BP,
  parameter int unsigned H_ACT   = DEF_H_ACT,
  parameter int unsigned H_TOTAL = DEF_H_TOTAL,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BP    = DEF_V_BP,
  parameter int unsigned V_ACT   = DEF_V_ACT,
  parameter int unsigned V_TOTAL = DEF_V_TOTAL,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  r_in,
  input  logic [2:0]  g_in,
  input  logic [1:0]  b_in,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [2:0]  pix_r,
  output logic [2:0]  pix_g,
  output logic [1:0]  pix_b,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_count
`ifdef FRAME_CRC_EN
  , output logic [15:0] frame_crc
`endif
);
  localparam logic [9:0] HA0 = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HA1 = 10'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [9:0] VA0 = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VA1 = 10'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [10:0] VT = 11'(V_TOTAL);
  logic hs_edge, vs_edge, armed_q, prev_bad_q;
  logic line_bad, frame_ev, frame_bad, valid_d, err_inc;
  logic [7:0] rgb_q, err_q;
  logic [9:0] hc_q, hc_d, vc_q, vc_d, x_d, y_d;
  state_e state_q, state_d;
  vga_sync_receiver_sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_hs (
    .clk(clk), .rst(rst), .sync_i(hsync_in), .strobe_o(hs_edge));
  vga_sync_receiver_sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_vs (
    .clk(clk), .rst(rst), .sync_i(vsync_in), .strobe_o(vs_edge));
  // Checks use 11 bits so a saturated counter (1023) never wraps into a match
  assign line_bad  = hs_edge && ({1'b0, hc_q} + 11'd1 != HT);
  assign frame_ev  = hs_edge && armed_q;
  assign frame_bad = frame_ev && ({1'b0, vc_q} + 11'd1 != VT);
  assign hc_d = hs_edge ? 10'd0 : hc_q + {9'd0, hc_q != 10'h3FF};
  assign vc_d = frame_ev ? 10'd0 : vc_q + {9'd0, hs_edge && vc_q != 10'h3FF};
  assign valid_d = state_q == LOCKED && hc_q >= HA0 && hc_q <= HA1 && vc_q >= VA0 && vc_q <= VA1;
  assign x_d = hc_q - HA0;
  assign y_d = vc_q - VA0;
  assign locked = state_q == LOCKED;
  assign err_count = err_q;
  always_comb begin
    state_d = state_q;
    err_inc = 1'b0;
    case (state_q)
      SEARCH:  state_d = frame_ev ? MEASURE : SEARCH;
      MEASURE: begin
        err_inc = line_bad || frame_bad;
        state_d = err_inc ? SEARCH : frame_ev ? LOCKED : MEASURE;
      end
      LOCKED:  begin
        err_inc = line_bad || frame_bad;
        state_d = (line_bad && prev_bad_q) || frame_bad ? SEARCH : LOCKED;
      end
      default: state_d = SEARCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      rgb_q <= '0;
      hc_q <= '0;
      vc_q <= '0;
      armed_q <= 1'b0;
      prev_bad_q <= 1'b0;
      state_q <= SEARCH;
      err_q <= '0;
      pix_valid <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      {pix_r, pix_g, pix_b} <= '0;
      frame_start <= 1'b0;
    end else begin
      rgb_q <= {r_in, g_in, b_in};
      hc_q <= hc_d;
      vc_q <= vc_d;
      // a vsync edge coinciding with an hsync edge arms for the following hsync edge
      armed_q <= vs_edge || (armed_q && !hs_edge);
      if (hs_edge) prev_bad_q <= line_bad;
      state_q <= state_d;
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
      pix_valid <= valid_d;
      frame_start <= valid_d && x_d == 10'd0 && y_d == 10'd0;
      if (valid_d) begin
        pix_x <= x_d;
        pix_y <= y_d;
        {pix_r, pix_g, pix_b} <= rgb_q;
      end
    end
  end
`ifdef FRAME_CRC_EN
  logic [15:0] acc_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= 16'hFFFF;
      frame_crc <= '0;
    end else if (frame_ev) begin
      acc_q <= 16'hFFFF;
      if (state_q == LOCKED) frame_crc <= acc_q;
    end else if (valid_d) begin
      acc_q <= crc16_byte(acc_q, rgb_q);
    end
  end
`endif
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: scoreboard bench for vga_sync_receiver in a reduced 20x10 mode
module tb_vga_sync_receiver;
  logic clk = 1'b0, rst = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic [2:0] r_in = '0, g_in = '0;
  logic [1:0] b_in = '0;
  logic pix_valid, frame_start, locked;
  logic [9:0] pix_x, pix_y;
  logic [2:0] pix_r, pix_g;
  logic [1:0] pix_b;
  logic [7:0] err_count;
`ifdef FRAME_CRC_EN
  logic [15:0] frame_crc;
`endif
  typedef logic [28:0] exp_t;
  exp_t q[$];
  exp_t mon_e;
  int passed = 0, total = 0, nvalid = 0, nfs = 0;
  bit all_ff = 1'b0;
  always #5 clk = ~clk;
  vga_sync_receiver #(
    .H_SYNC(4), .H_BP(3), .H_ACT(8), .H_TOTAL(20),
    .V_SYNC(2), .V_BP(2), .V_ACT(4), .V_TOTAL(10), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .locked(locked), .err_count(err_count)
`ifdef FRAME_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  always @(negedge clk) begin
    if (rst) begin
      if (frame_start) nfs++;
      if (pix_valid) begin
        nvalid++;
        mon_e = q.size() != 0 ? q.pop_front() : '1;
        chk("pix", {pix_x, pix_y, pix_r, pix_g, pix_b, frame_start}, mon_e);
      end
    end
  end
  // line index i: hsync low for i<4, pixel x = i-8 for i in 8..15; line L: vsync low for L<2, row y = L-5 for L in 5..8
  task automatic drive_line(input int len, input int L, input bit vs_low, input bit exp_pix);
    int x;
    logic [7:0] px;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      x = i - 8;
      px = all_ff ? 8'hFF : {x[2:0], L[2:0], i[1:0]};
      hsync_in = i < 4 ? 1'b0 : 1'b1;
      vsync_in = !vs_low;
      {r_in, g_in, b_in} = px;
      if (exp_pix && i >= 8 && i <= 15 && L >= 5 && L <= 8)
        q.push_back({10'(x), 10'(L - 5), px, i == 8 && L == 5});
    end
  endtask
  task automatic drive_frame(input string nm, input int nlines, input bit exp_pix, input int bad_a, input int bad_b);
    int v0, f0, nact;
    v0 = nvalid;
    f0 = nfs;
    nact = 0;
    for (int L = 0; L < nlines; L++) drive_line((L == bad_a || L == bad_b) ? 19 : 20, L, L < 2, exp_pix);
    for (int L = 5; L <= 8; L++) if (L < nlines) nact++;
    chk({nm, "_nvalid"}, nvalid - v0, exp_pix ? nact * 8 : 0);
    chk({nm, "_nfs"}, nfs - f0, (exp_pix && nlines > 5) ? 1 : 0);
    chk({nm, "_queue"}, q.size(), 0);
  endtask
  task automatic chk_state(input string nm, input bit exp_lock, input int exp_err);
    chk({nm, "_locked"}, locked, exp_lock);
    chk({nm, "_err"}, err_count, exp_err);
  endtask
  function automatic logic [15:0] crc_ff(input int nbytes);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int k = 0; k < nbytes * 8; k++) begin
      fb = c[15] ^ 1'b1;
      c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
  initial begin
    repeat (4) @(negedge clk);
    chk_state("rst0", 1'b0, 0);
    chk("rst0_pix", {pix_valid, frame_start, pix_x, pix_y, pix_r, pix_g, pix_b}, 0);
    rst = 1'b1;
    drive_frame("A", 10, 1'b0, -1, -1);
    chk_state("A", 1'b0, 0);
    drive_frame("B", 10, 1'b1, -1, -1);
    chk_state("B", 1'b1, 0);
    drive_frame("C", 10, 1'b1, -1, -1);
    chk_state("C", 1'b1, 0);
    drive_frame("D", 10, 1'b1, 3, -1);
    chk_state("D", 1'b1, 1);
    drive_frame("E", 10, 1'b0, 2, 3);
    chk_state("E", 1'b0, 3);
    drive_frame("F", 10, 1'b0, -1, -1);
    chk_state("F", 1'b0, 3);
    drive_frame("G", 10, 1'b1, -1, -1);
    chk_state("G", 1'b1, 3);
    drive_frame("H", 10, 1'b1, -1, -1);
    drive_line(1044, 9, 1'b0, 1'b0);
    chk_state("long", 1'b1, 3);
    drive_frame("I", 10, 1'b0, -1, -1);
    chk_state("I", 1'b0, 5);
    drive_frame("J", 10, 1'b0, -1, -1);
    drive_frame("K", 10, 1'b1, -1, -1);
    chk_state("K", 1'b1, 5);
    drive_frame("L", 9, 1'b1, -1, -1);
    chk_state("L", 1'b1, 5);
    drive_frame("M", 10, 1'b0, -1, -1);
    chk_state("M", 1'b0, 6);
    drive_frame("N", 10, 1'b0, -1, -1);
    drive_frame("O", 10, 1'b1, -1, -1);
    chk_state("O", 1'b1, 6);
`ifdef FRAME_CRC_EN
    all_ff = 1'b1;
    drive_frame("P", 10, 1'b1, -1, -1);
    all_ff = 1'b0;
    drive_frame("Q", 10, 1'b1, -1, -1);
    chk("crc", frame_crc, crc_ff(32));
`endif
    drive_frame("R", 7, 1'b1, -1, -1);
    rst = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    chk_state("rst1", 1'b0, 0);
    chk("rst1_pix", {pix_valid, frame_start, pix_x, pix_y, pix_r, pix_g, pix_b}, 0);
    rst = 1'b1;
    for (int L = 7; L < 10; L++) drive_line(20, L, 1'b0, 1'b0);
    drive_frame("S", 10, 1'b0, -1, -1);
    chk_state("S", 1'b0, 0);
    drive_frame("T", 10, 1'b1, -1, -1);
    chk_state("T", 1'b1, 0);
    repeat (5) @(negedge clk);
    chk("end_queue", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
